mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage pipeline, sitting directly downstream of the EX/MEM pipeline register and feeding write-back. It holds a word-addressed data RAM with a fixed multi-cycle access latency. A small FSM stalls the upstream pipeline while an access is in flight. The block also contains the MEM/WB pipeline register.

## Interface
- `DEPTH`, default 256: data RAM size in 32-bit words; power of two, 4..4096.
- `LATENCY`, default 2: cycles an aligned load/store holds the pipeline; legal range 1..15.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high; clock clk.
- `Address` in 32: byte address (ALU result) from EX/MEM.
- `WriteDataMEM` in 32: store data.
- `WriteRegMEM` in 5: destination register.
- `RegWriteMEM`, `MemReadMEM`, `MemWriteMEM`, `MemtoRegMEM` in 1 each: control from EX/MEM.
- `StallMEM` out 1: freeze PC, IF/ID, ID/EX and EX/MEM this cycle (combinational).
- `ReadDataWB` out 32: loaded word.
- `ALUResultWB` out 32: registered `Address`.
- `WriteRegWB` out 5: registered destination register.
- `RegWriteWB`, `MemtoRegWB` out 1 each: registered control.
- `AlignErr` out 1: sticky flag, set by any misaligned access.

## Operation
- Access = `MemReadMEM | MemWriteMEM`. Aligned means `Address[1:0]==0`.
- RAM index is `Address[log2(DEPTH)+1:2]`. Upper bits are ignored, so addresses wrap.
- FSM states:
  - IDLE: on an aligned access, load cnt=LATENCY-1. Go to BUSY if cnt>0, otherwise go to DONE. Any other input stays in IDLE.
  - BUSY: decrement cnt; go to DONE when cnt==1 before the decrement.
  - DONE: go to IDLE unconditionally.
- `StallMEM` = (IDLE & aligned access) | BUSY. It is low in DONE.
- RAM commit happens only at the end of the DONE cycle. A store writes `WriteDataMEM`; a load captures `ram[idx]` into `ReadDataWB`.
- If MemRead and MemWrite are both set, the access is a store. `ReadDataWB` is loaded with 0.
- Misaligned access:
  - No stall and no RAM write.
  - `AlignErr` is set.
  - The instruction retires as a bubble: `RegWriteWB`=0, `MemtoRegWB`=0, `ReadDataWB`=0.
- Non-memory instruction: passes through in one cycle with no stall. MEM/WB captures all fields and `ReadDataWB` holds its previous value.
- While `StallMEM`=1, MEM/WB loads a bubble: `RegWriteWB`=0 and `MemtoRegWB`=0. `ALUResultWB`, `WriteRegWB` and `ReadDataWB` hold.
- RAM initialises to zero at time 0. Reset does not clear the RAM.

## Timing
- Reset values: all WB outputs 0, `AlignErr`=0, FSM in IDLE, cnt=0. `StallMEM` is 0 from the cycle after reset is sampled.
- Aligned access presented in cycle N:
  - `StallMEM` is high in cycles N..N+LATENCY-1.
  - Cycle N+LATENCY is DONE.
  - WB outputs are valid from cycle N+LATENCY+1.
  - EX/MEM holds the instruction through cycle N+LATENCY and advances at the end of that cycle.
- Back-to-back accesses: the next instruction is seen in IDLE at cycle N+LATENCY+1, which gives LATENCY+1 cycles per memory op. The FSM never re-issues the same access.
- LATENCY=1: IDLE→DONE, stall high for exactly one cycle.
- Reset asserted in BUSY or DONE: the FSM goes to IDLE, a pending store is discarded (RAM unchanged), and WB outputs are cleared.
- Non-memory throughput is one instruction per cycle with 1-cycle latency to WB.

## Structure
- Package `mem_pkg`: FSM state enum (IDLE, BUSY, DONE), cnt width constant (4), opcode-independent control bundle typedef for the MEM/WB fields.
- Sub-module `data_ram`: single-port, synchronous write, synchronous read-on-enable, parameterised by `DEPTH`.
- The FSM, stall logic and MEM/WB register live in `mem_stage`.

## Test plan
- LATENCY=2, store 0xDEADBEEF to 0x10, then load 0x10:
  - Each op gives `StallMEM` high for 2 cycles.
  - The load gives `ReadDataWB`=0xDEADBEEF, `MemtoRegWB`=1.
  - Total is 6 cycles for both ops.
- Stream of 4 ALU ops, no memory access: no stall, and `ALUResultWB`/`WriteRegWB` follow the inputs with 1-cycle latency.
- Load from 0x12: no stall, `AlignErr`=1 and stays set; WB shows a bubble with `ReadDataWB`=0; RAM is unchanged.
- DEPTH=256, store 0x55 to 0x400, then load 0x000: the load returns 0x55 (wrap).
- LATENCY=4, reset asserted in the 2nd BUSY cycle of a store to 0x20:
  - `StallMEM` drops after the reset is sampled.
  - A later load of 0x20 returns the old value (0).
- LATENCY=1, MemRead=MemWrite=1 with data 0x1234 at 0x8: treated as a store, `ReadDataWB`=0, a later load returns 0x1234.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory-access stage
//
// Purpose: FSM state encoding, access counter width and the MEM/WB control
// bundle used by mem_stage.
// Ports: none (package).
package mem_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    // Opcode-independent fields carried from EX/MEM into MEM/WB.
    typedef struct packed {
        logic        reg_write;
        logic        memto_reg;
        logic [4:0]  write_reg;
        logic [31:0] alu_result;
    } mem_wb_ctrl_t;

endpackage

// File: rtl/data_ram.sv
// rtl/data_ram.sv - single-port word RAM, synchronous write and read-on-enable
//
// Purpose: data storage for the memory-access stage.
// Ports:
//   clk   - clock
//   we    - write enable, writes wdata to mem[addr] at the clock edge
//   re    - read enable, registers mem[addr] into rdata at the clock edge
//   addr  - word index
//   wdata - write data
//   rdata - registered read data, holds when re is low
module data_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    // Contents start at zero; reset deliberately leaves the array alone.
    logic [31:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory-access stage with multi-cycle data RAM
//
// Purpose: performs loads/stores with a fixed access latency, stalls the
// upstream pipeline while an access is in flight, flags misaligned accesses
// and holds the MEM/WB pipeline register.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   Address, WriteDataMEM      - byte address / store data from EX/MEM
//   WriteRegMEM                - destination register from EX/MEM
//   RegWriteMEM, MemReadMEM,
//   MemWriteMEM, MemtoRegMEM   - control from EX/MEM
//   StallMEM                   - combinational freeze of upstream stages
//   ReadDataWB, ALUResultWB,
//   WriteRegWB, RegWriteWB,
//   MemtoRegWB                 - MEM/WB register outputs
//   AlignErr                   - sticky misaligned-access flag
module mem_stage
    import mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteDataMEM,
    input  logic [4:0]  WriteRegMEM,
    input  logic        RegWriteMEM,
    input  logic        MemReadMEM,
    input  logic        MemWriteMEM,
    input  logic        MemtoRegMEM,
    output logic        StallMEM,
    output logic [31:0] ReadDataWB,
    output logic [31:0] ALUResultWB,
    output logic [4:0]  WriteRegWB,
    output logic        RegWriteWB,
    output logic        MemtoRegWB,
    output logic        AlignErr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    mem_state_e       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             stall;
    logic             ram_re;
    logic             ram_we;
    logic [31:0]      ram_rdata;
    logic [AW-1:0]    ram_idx;
    mem_wb_ctrl_t     wb;
    logic [31:0]      read_data;
    logic             align_err;

    logic access, aligned, aligned_access, misaligned_access;

    assign access            = MemReadMEM | MemWriteMEM;
    assign aligned           = (Address[1:0] == 2'b00);
    assign aligned_access    = access & aligned;
    assign misaligned_access = access & ~aligned;
    assign ram_idx           = Address[AW+1:2];

    // Next state, counter and stall.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (aligned_access) begin
                    stall    = 1'b1;
                    cnt_next = LAT_M1;
                    if (LAT_M1 != '0) begin
                        state_next = BUSY;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            BUSY: begin
                stall    = 1'b1;
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The read is launched in the last stalled cycle so the RAM's registered
    // output is ready during DONE, where it is committed to MEM/WB.
    assign ram_re = stall & (state_next == DONE) & MemReadMEM & ~MemWriteMEM;
    // A store commits only when DONE completes without reset.
    assign ram_we = (state == DONE) & MemWriteMEM & ~reset;

    data_ram #(
        .DEPTH (DEPTH)
    ) u_data_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_idx),
        .wdata (WriteDataMEM),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            wb        <= '0;
            read_data <= '0;
            align_err <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (stall) begin
                // Bubble into WB; data fields hold.
                wb.reg_write <= 1'b0;
                wb.memto_reg <= 1'b0;
            end else if (misaligned_access) begin
                wb <= '{reg_write: 1'b0, memto_reg: 1'b0,
                        write_reg: WriteRegMEM, alu_result: Address};
                read_data <= '0;
                align_err <= 1'b1;
            end else begin
                wb <= '{reg_write: RegWriteMEM, memto_reg: MemtoRegMEM,
                        write_reg: WriteRegMEM, alu_result: Address};
                if (state == DONE) begin
                    if (MemWriteMEM) begin
                        // Read+write is treated as a store returning zero.
                        if (MemReadMEM) begin
                            read_data <= '0;
                        end
                    end else if (MemReadMEM) begin
                        read_data <= ram_rdata;
                    end
                end
            end
        end
    end

    assign StallMEM    = stall;
    assign ReadDataWB  = read_data;
    assign ALUResultWB = wb.alu_result;
    assign WriteRegWB  = wb.write_reg;
    assign RegWriteWB  = wb.reg_write;
    assign MemtoRegWB  = wb.memto_reg;
    assign AlignErr    = align_err;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage at LATENCY 2, 4 and 1
module tb_mem_stage;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [N];
    logic [31:0] address   [N];
    logic [31:0] wdata     [N];
    logic [4:0]  wreg      [N];
    logic        regwrite  [N];
    logic        memread   [N];
    logic        memwrite  [N];
    logic        memtoreg  [N];
    logic        stall     [N];
    logic [31:0] rdata_wb  [N];
    logic [31:0] alu_wb    [N];
    logic [4:0]  wreg_wb   [N];
    logic        rw_wb     [N];
    logic        m2r_wb    [N];
    logic        align_err [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_stage #(
            .DEPTH   (256),
            .LATENCY (g == 0 ? 2 : (g == 1 ? 4 : 1))
        ) u_dut (
            .clk          (clk),
            .reset        (rst[g]),
            .Address      (address[g]),
            .WriteDataMEM (wdata[g]),
            .WriteRegMEM  (wreg[g]),
            .RegWriteMEM  (regwrite[g]),
            .MemReadMEM   (memread[g]),
            .MemWriteMEM  (memwrite[g]),
            .MemtoRegMEM  (memtoreg[g]),
            .StallMEM     (stall[g]),
            .ReadDataWB   (rdata_wb[g]),
            .ALUResultWB  (alu_wb[g]),
            .WriteRegWB   (wreg_wb[g]),
            .RegWriteWB   (rw_wb[g]),
            .MemtoRegWB   (m2r_wb[g]),
            .AlignErr     (align_err[g])
        );
    end

    // Reference model: word memory per instance, last loaded word, sticky flag.
    logic [31:0] mdl_mem  [N][256];
    logic [31:0] mdl_rd   [N];
    bit          rd_known [N];
    bit          mdl_align[N];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge clk) cyc = cyc + 1;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 4 : 1);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input int k);
        address[k]  = '0;
        wdata[k]    = '0;
        wreg[k]     = '0;
        regwrite[k] = 1'b0;
        memread[k]  = 1'b0;
        memwrite[k] = 1'b0;
        memtoreg[k] = 1'b0;
    endtask

    task automatic model_reset(input int k);
        mdl_align[k] = 1'b0;
        mdl_rd[k]    = '0;
        rd_known[k]  = 1'b1;
    endtask

    // Presents one instruction, holds it while the stage stalls, then checks
    // stall length and the MEM/WB contents once it has retired.
    task automatic run_op(input int k, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] wr_reg, input logic rw, input logic m2r);
        int   n;
        int   exp_n;
        int   idx;
        logic s;
        bit   acc;
        bit   al;
        address[k]  = addr;
        wdata[k]    = data;
        wreg[k]     = wr_reg;
        regwrite[k] = rw;
        memread[k]  = rd;
        memwrite[k] = wr;
        memtoreg[k] = m2r;
        n = 0;
        forever begin
            @(negedge clk);
            s = stall[k];
            tick();
            if (!s) break;
            n++;
            if (n > 20) break;
        end
        nop(k);

        acc   = rd | wr;
        al    = (addr % 4) == 0;
        idx   = (addr / 4) % 256;
        exp_n = (acc && al) ? lat_of(k) : 0;
        check_eq("stall_cycles", n, exp_n);
        if (acc && !al) begin
            mdl_align[k] = 1'b1;
            mdl_rd[k]    = '0;
            rd_known[k]  = 1'b1;
            check_eq("misal_regwrite", rw_wb[k], 0);
            check_eq("misal_memtoreg", m2r_wb[k], 0);
        end else begin
            if (wr) begin
                mdl_mem[k][idx] = data;
                mdl_rd[k]       = '0;
                rd_known[k]     = rd;
            end else if (rd) begin
                mdl_rd[k]   = mdl_mem[k][idx];
                rd_known[k] = 1'b1;
            end
            check_eq("regwrite_wb", rw_wb[k], rw);
            check_eq("memtoreg_wb", m2r_wb[k], m2r);
            check_eq("aluresult_wb", alu_wb[k], addr);
            check_eq("writereg_wb", wreg_wb[k], wr_reg);
        end
        if (rd_known[k]) check_eq("readdata_wb", rdata_wb[k], mdl_rd[k]);
        check_eq("align_err", align_err[k], mdl_align[k]);
    endtask

    task automatic random_op(input int k);
        int          kind;
        logic [31:0] a;
        kind = $urandom_range(0, 3);
        a = ($urandom_range(0, 15) << 2) | ($urandom_range(0, 3) << 10);
        if ($urandom_range(0, 7) == 0) a = a | $urandom_range(1, 3);
        run_op(k, kind[0], kind[1], a, $urandom, 5'($urandom),
               1'($urandom), 1'($urandom));
    endtask

    initial begin : main
        int c0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 256; i++) mdl_mem[k][i] = '0;
            rst[k] = 1'b1;
            nop(k);
            model_reset(k);
        end
        tick();
        tick();
        for (int k = 0; k < N; k++) rst[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check_eq("rst_stall", stall[k], 0);
            check_eq("rst_readdata", rdata_wb[k], 0);
            check_eq("rst_aluresult", alu_wb[k], 0);
            check_eq("rst_writereg", wreg_wb[k], 0);
            check_eq("rst_regwrite", rw_wb[k], 0);
            check_eq("rst_memtoreg", m2r_wb[k], 0);
            check_eq("rst_alignerr", align_err[k], 0);
        end
        tick();

        // LATENCY=2: store then load, 3 cycles each.
        c0 = cyc;
        run_op(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0);
        run_op(0, 1'b1, 1'b0, 32'h10, 32'h0, 5'd7, 1'b1, 1'b1);
        check_eq("st_ld_total_cycles", cyc - c0, 6);
        check_eq("st_ld_value", rdata_wb[0], 32'hDEADBEEF);

        // Four ALU ops back to back.
        c0 = cyc;
        for (int i = 0; i < 4; i++)
            run_op(0, 1'b0, 1'b0, $urandom, 32'h0, 5'($urandom), 1'b1, 1'b0);
        check_eq("alu_stream_cycles", cyc - c0, 4);

        // Misaligned load and store: bubble, sticky flag, RAM untouched.
        run_op(0, 1'b1, 1'b0, 32'h12, 32'h0, 5'd3, 1'b1, 1'b1);
        check_eq("misal_readdata", rdata_wb[0], 0);
        run_op(0, 1'b0, 1'b1, 32'h13, 32'h0BADBAD0, 5'd0, 1'b0, 1'b0);
        run_op(0, 1'b1, 1'b0, 32'h10, 32'h0, 5'd4, 1'b1, 1'b1);
        check_eq("misal_ram_unchanged", rdata_wb[0], 32'hDEADBEEF);

        // Address wrap at DEPTH=256.
        run_op(0, 1'b0, 1'b1, 32'h400, 32'h55, 5'd0, 1'b0, 1'b0);
        run_op(0, 1'b1, 1'b0, 32'h000, 32'h0, 5'd9, 1'b1, 1'b1);
        check_eq("wrap_load", rdata_wb[0], 32'h55);

        // LATENCY=4: reset during the second BUSY cycle of a store.
        address[1]  = 32'h20;
        wdata[1]    = 32'hCAFEF00D;
        memwrite[1] = 1'b1;
        @(negedge clk);
        check_eq("busy_rst_stall_idle", stall[1], 1);
        tick();
        tick();
        rst[1] = 1'b1;
        @(negedge clk);
        check_eq("busy_rst_stall_busy2", stall[1], 1);
        tick();
        rst[1] = 1'b0;
        nop(1);
        model_reset(1);
        @(negedge clk);
        check_eq("busy_rst_stall_after", stall[1], 0);
        check_eq("busy_rst_regwrite", rw_wb[1], 0);
        check_eq("busy_rst_aluresult", alu_wb[1], 0);
        tick();
        run_op(1, 1'b1, 1'b0, 32'h20, 32'h0, 5'd2, 1'b1, 1'b1);
        check_eq("busy_rst_store_dropped", rdata_wb[1], 0);

        // LATENCY=1: read+write is a store returning zero.
        run_op(2, 1'b1, 1'b1, 32'h8, 32'h1234, 5'd6, 1'b1, 1'b1);
        check_eq("rdwr_readdata", rdata_wb[2], 0);
        run_op(2, 1'b1, 1'b0, 32'h8, 32'h0, 5'd6, 1'b1, 1'b1);
        check_eq("rdwr_later_load", rdata_wb[2], 32'h1234);

        // Randomized mix on every instance.
        for (int k = 0; k < N; k++)
            for (int i = 0; i < 40; i++)
                random_op(k);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
